lc3_mem_responder: RTL and testbench
====================================

# lc3_mem_responder

Memory-side responder for the LC-3 datapath. It services the read and write requests that the controller issues through MAR/MDR (`ldMAR`, `ldMDR`, `memWE`), using a four-phase req/ready handshake. It contains the word-addressed main RAM with a programmable number of wait states, plus the keyboard and display memory-mapped device registers. It sits between the MAR/MDR registers and the outside world and drives the LC-3 "R" (memory ready) condition back to the control FSM.

## Interface
- `ADDR_BITS`, default 10: RAM holds 2^ADDR_BITS 16-bit words at x0000..(2^ADDR_BITS−1).
- `WAIT_STATES`, default 2: extra cycles per access; legal range 0..15.
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `req`, in, 1: access request, held by the initiator until `ready` is seen.
- `we`, in, 1: 1 means write, 0 means read; sampled with `req`.
- `addr`, in, 16: word address (MAR).
- `wdata`, in, 16: write data (MDR).
- `rdata`, out, 16: read data, valid while `ready` is 1.
- `ready`, out, 1: access complete.
- `kb_data`, in, 8: keyboard character.
- `kb_valid`, in, 1: one-cycle strobe; a new character is present.
- `dsp_data`, out, 8: display character.
- `dsp_valid`, out, 1: display character pending.
- `dsp_ready`, in, 1: display consumed the character (handshake with `dsp_valid`).

## Operation
- **FSM states:**
  - IDLE → BUSY when `req` is 1. At that edge, latch `addr`, `we` and `wdata`, and load the wait counter with `WAIT_STATES`.
  - BUSY: decrement the counter each cycle while it is nonzero. In the cycle the counter is 0, perform the access and go to ACK.
  - ACK: `ready` is 1. Stay while `req` is 1. Go to IDLE on the edge where `req` is 0.
- **Handshake:** four-phase. One request yields exactly one access, whatever the `req` hold time. Input changes during BUSY or ACK are ignored, since the latched copies are used.
- **Address decode (latched address):**
  - Below 2^ADDR_BITS: RAM.
  - xFE00: KBSR.
  - xFE02: KBDR.
  - xFE04: DSR.
  - xFE06: DDR.
  - Anything else is unmapped: reads return x0000 and writes are dropped, but the access still completes with `ready`.
- **Reads:** `rdata` is loaded at the access edge and held until the next access.
  - KBSR = {kb_full, 15'b0}.
  - KBDR = {8'b0, kb_reg}; reading it clears `kb_full`.
  - DSR = {~dsp_valid, 15'b0}.
  - DDR reads as x0000.
- **Writes:**
  - RAM is written with `wdata`.
  - DDR write when `dsp_valid` is 0: `dsp_data` ← `wdata[7:0]` and `dsp_valid` ← 1.
  - DDR write when `dsp_valid` is 1: dropped.
  - Writes to KBSR, KBDR and DSR are ignored.
- **Keyboard:**
  - `kb_valid` with `kb_full` 0: `kb_reg` ← `kb_data` and `kb_full` ← 1.
  - `kb_valid` with `kb_full` 1: the character is dropped (overrun).
  - `kb_valid` in the same cycle as a KBDR read access: the read returns the old `kb_reg`, the new character is latched, and `kb_full` stays 1.
- **Display:** `dsp_valid` stays 1 until sampled with `dsp_ready`=1, then clears on that edge. A DDR write on the same edge as that clear is dropped.
- The keyboard and display logic runs every cycle, independent of the FSM state.

## Timing
- **Reset values:**
  - State IDLE.
  - `ready` 0, `rdata` x0000.
  - `dsp_valid` 0, `dsp_data` x00.
  - `kb_full` 0, `kb_reg` x00.
  - Wait counter 0.
  - RAM contents are not reset.
- **Latency:** `req` sampled at edge N gives `ready`=1 after edge N+1+WAIT_STATES. The RAM write commits at that same edge.
- `ready` falls one edge after `req` is sampled low. A new `req` can be accepted at the edge after that, so a back-to-back access takes at minimum 3+WAIT_STATES cycles.
- `ready` and `rdata` are registered; there are no combinational input-to-output paths.
- **Reset mid-operation:** `reset_n` low in BUSY aborts the access. A write is committed only if the access edge precedes the reset assertion. `ready` goes to 0 immediately.
- **Widths:** the wait counter is 4 bits. Address comparisons use all 16 bits, and RAM indexing uses `addr[ADDR_BITS-1:0]` only after the range check passes.

## Test plan
- **RAM round trip:** WAIT_STATES=2. Write x1234 to x0005 with `req` held. Expect `ready` exactly 3 edges after `req` is sampled. Then read x0005: expect `rdata`=x1234 with `ready`.
- **Zero wait states and long hold:** WAIT_STATES=0. Hold `req` 5 cycles after `ready`. Expect `ready` at edge N+1, `ready` held high, exactly one write committed, and IDLE one edge after `req` drops.
- **Keyboard path:**
  - `kb_valid` with x41. Read KBSR: expect x8000. Read KBDR: expect x0041. Read KBSR again: expect x0000.
  - A second `kb_valid` (x42) while `kb_full` is 1 is dropped. The next KBDR read returns x0041.
- **Display path:**
  - Write x0058 to DDR: expect `dsp_valid`=1 and `dsp_data`=x58, and a DSR read returns x0000.
  - A write of x0059 to DDR while pending is dropped.
  - After `dsp_ready` pulses, `dsp_valid` is 0 and DSR reads x8000.
- **Unmapped address:** read xC000 with ADDR_BITS=10: expect `rdata`=x0000 and a normal `ready`. A write to xC000 must not alias into RAM: x0000 keeps its prior value.
- **Reset mid-access:** with WAIT_STATES=3, pull `reset_n` low one cycle into BUSY on a write to x0007 that previously held xAAAA. Expect `ready` and `rdata` at 0 immediately, and a later read of x0007 returns xAAAA.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: word RAM with programmable wait states plus keyboard/display
// device registers, serviced through a four-phase req/ready handshake.
module lc3_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic [7:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready
);

  localparam logic [16:0] RAM_LIMIT = 17'd1 << ADDR_BITS;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic        r_we;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_ready;
  logic        r_kb_full;
  logic [7:0]  r_kb_reg;
  logic        r_dsp_valid;
  logic [7:0]  r_dsp_data;
  logic [15:0] r_mem [0:(1 << ADDR_BITS) - 1];

  logic        w_accept;
  logic        w_access;
  logic        w_sel_ram;
  logic        w_sel_kbsr;
  logic        w_sel_kbdr;
  logic        w_sel_dsr;
  logic        w_sel_ddr;
  logic        w_ram_we;
  logic        w_kbdr_rd;
  logic        w_ddr_wr;
  logic [15:0] w_rd_data;

  assign rdata     = r_rdata;
  assign ready     = r_ready;
  assign dsp_data  = r_dsp_data;
  assign dsp_valid = r_dsp_valid;

  // Next-state logic of the handshake FSM
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req) w_next = ST_BUSY;
        else     w_next = ST_IDLE;
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) w_next = ST_ACK;
        else               w_next = ST_BUSY;
      end
      ST_ACK: begin
        if (req) w_next = ST_ACK;
        else     w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Address decode on the latched address and read-data mux
  always_comb begin
    w_accept   = (r_state == ST_IDLE) && req;
    w_access   = (r_state == ST_BUSY) && (r_cnt == 4'd0);
    // Full 16-bit range check first so device addresses never alias into RAM
    w_sel_ram  = ({1'b0, r_addr} < RAM_LIMIT);
    w_sel_kbsr = !w_sel_ram && (r_addr == KBSR_ADDR);
    w_sel_kbdr = !w_sel_ram && (r_addr == KBDR_ADDR);
    w_sel_dsr  = !w_sel_ram && (r_addr == DSR_ADDR);
    w_sel_ddr  = !w_sel_ram && (r_addr == DDR_ADDR);
    w_ram_we   = w_access && r_we && w_sel_ram;
    w_kbdr_rd  = w_access && !r_we && w_sel_kbdr;
    w_ddr_wr   = w_access && r_we && w_sel_ddr;
    w_rd_data  = 16'h0000;
    if (w_sel_ram) begin
      w_rd_data = r_mem[r_addr[ADDR_BITS-1:0]];
    end else if (w_sel_kbsr) begin
      w_rd_data = {r_kb_full, 15'h0000};
    end else if (w_sel_kbdr) begin
      w_rd_data = {8'h00, r_kb_reg};
    end else if (w_sel_dsr) begin
      w_rd_data = {~r_dsp_valid, 15'h0000};
    end else begin
      w_rd_data = 16'h0000;
    end
  end

  // FSM state, wait counter and request latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 16'h0000;
      r_we    <= 1'b0;
      r_wdata <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= WAIT_LOAD;
        r_addr  <= addr;
        r_we    <= we;
        r_wdata <= wdata;
      end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Registered ready and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
      r_rdata <= 16'h0000;
    end else begin
      r_ready <= (w_next == ST_ACK);
      if (w_access && !r_we) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  // Main RAM; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[r_addr[ADDR_BITS-1:0]] <= r_wdata;
    end
  end

  // Keyboard receive register; a new character during a KBDR read keeps kb_full set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kb_full <= 1'b0;
      r_kb_reg  <= 8'h00;
    end else if (w_kbdr_rd) begin
      if (kb_valid) begin
        r_kb_reg  <= kb_data;
        r_kb_full <= 1'b1;
      end else begin
        r_kb_full <= 1'b0;
      end
    end else if (kb_valid && !r_kb_full) begin
      r_kb_reg  <= kb_data;
      r_kb_full <= 1'b1;
    end
  end

  // Display transmit register; a consume edge wins over a coincident DDR write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dsp_valid <= 1'b0;
      r_dsp_data  <= 8'h00;
    end else if (r_dsp_valid && dsp_ready) begin
      r_dsp_valid <= 1'b0;
    end else if (w_ddr_wr && !r_dsp_valid) begin
      r_dsp_data  <= r_wdata[7:0];
      r_dsp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Randomized bench for lc3_mem_responder: three instances (0, 2 and 3 wait states)
// checked against a behavioural memory/device model.
module tb_lc3_mem_responder;

  localparam int NI = 3;

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  logic        clk;
  logic        rst_n     [NI];
  logic        req       [NI];
  logic        we        [NI];
  logic [15:0] addr      [NI];
  logic [15:0] wdata     [NI];
  logic [15:0] rdata     [NI];
  logic        ready     [NI];
  logic [7:0]  kb_data   [NI];
  logic        kb_valid  [NI];
  logic [7:0]  dsp_data  [NI];
  logic        dsp_valid [NI];
  logic        dsp_ready [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    lc3_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(ws_of(g))) u_dut (
      .clk(clk), .reset_n(rst_n[g]), .req(req[g]), .we(we[g]), .addr(addr[g]),
      .wdata(wdata[g]), .rdata(rdata[g]), .ready(ready[g]), .kb_data(kb_data[g]),
      .kb_valid(kb_valid[g]), .dsp_data(dsp_data[g]), .dsp_valid(dsp_valid[g]),
      .dsp_ready(dsp_ready[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [15:0] m_ram [NI][1024];
  bit          m_ok  [NI][1024];
  bit          m_kbf [NI];
  logic [7:0]  m_kbr [NI];
  bit          m_dv  [NI];
  logic [7:0]  m_dd  [NI];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(int k);
    m_kbf[k] = 0; m_kbr[k] = 8'h00; m_dv[k] = 0; m_dd[k] = 8'h00;
  endtask

  // One completed access as seen from the processor's point of view
  task automatic model_access(int k, bit w, logic [15:0] a, logic [15:0] d, bit inj,
                              logic [7:0] kd, output logic [15:0] rd);
    bit kb_done;
    kb_done = 0;
    rd = 16'h0000;
    if (a < 16'd1024) begin
      if (w) begin m_ram[k][a[9:0]] = d; m_ok[k][a[9:0]] = 1; end
      else rd = m_ram[k][a[9:0]];
    end else if (a == 16'hFE00) begin
      if (!w) rd = m_kbf[k] ? 16'h8000 : 16'h0000;
    end else if (a == 16'hFE02) begin
      if (!w) begin
        rd = {8'h00, m_kbr[k]};
        kb_done = 1;
        if (inj) begin m_kbr[k] = kd; m_kbf[k] = 1; end
        else m_kbf[k] = 0;
      end
    end else if (a == 16'hFE04) begin
      if (!w) rd = m_dv[k] ? 16'h0000 : 16'h8000;
    end else if (a == 16'hFE06) begin
      if (w && !m_dv[k]) begin m_dd[k] = d[7:0]; m_dv[k] = 1; end
    end
    if (inj && !kb_done && !m_kbf[k]) begin m_kbr[k] = kd; m_kbf[k] = 1; end
  endtask

  task automatic access(int k, bit w, logic [15:0] a, logic [15:0] d, int hold,
                        bit inj, logic [7:0] kd, string tag);
    logic [15:0] exp_rd;
    int e;
    bit got;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    tick();
    we[k] = 1'($urandom); addr[k] = 16'($urandom); wdata[k] = 16'($urandom);
    e = 0; got = 0;
    while (!got && e < 40) begin
      if (inj && e == ws_of(k)) begin kb_data[k] = kd; kb_valid[k] = 1'b1; end
      tick();
      e++;
      kb_valid[k] = 1'b0;
      if (ready[k]) got = 1;
    end
    chk({tag, "_lat"}, e, ws_of(k) + 1);
    model_access(k, w, a, d, inj, kd, exp_rd);
    if (!w) chk({tag, "_rd"}, rdata[k], exp_rd);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold"}, ready[k], 1);
    end
    req[k] = 1'b0;
    tick();
    chk({tag, "_drop"}, ready[k], 0);
    if (!w) chk({tag, "_keep"}, rdata[k], exp_rd);
  endtask

  task automatic kb_strobe(int k, logic [7:0] d);
    kb_data[k] = d; kb_valid[k] = 1'b1;
    tick();
    kb_valid[k] = 1'b0;
    if (!m_kbf[k]) begin m_kbr[k] = d; m_kbf[k] = 1; end
  endtask

  task automatic dsp_pulse(int k);
    dsp_ready[k] = 1'b1;
    tick();
    dsp_ready[k] = 1'b0;
    m_dv[k] = 0;
  endtask

  task automatic chk_dsp(int k, string tag);
    chk({tag, "_dv"}, dsp_valid[k], m_dv[k]);
    if (m_dv[k]) chk({tag, "_dd"}, dsp_data[k], m_dd[k]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int r;
    int n;
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = 16'h0000;
      wdata[k] = 16'h0000; kb_data[k] = 8'h00; kb_valid[k] = 1'b0; dsp_ready[k] = 1'b0;
      model_reset(k);
      for (int i = 0; i < 1024; i++) m_ok[k][i] = 0;
    end
    tick(); tick();
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    tick();
    for (int k = 0; k < NI; k++) begin
      chk("reset_ready", ready[k], 0);
      chk("reset_rdata", rdata[k], 0);
      chk("reset_dv", dsp_valid[k], 0);
      chk("reset_dd", dsp_data[k], 0);
      access(k, 0, 16'hFE00, 16'h0000, 0, 0, 8'h00, "reset_kbsr");
    end

    // RAM round trip and long hold
    access(1, 1, 16'h0005, 16'h1234, 0, 0, 8'h00, "rt_wr");
    access(1, 0, 16'h0005, 16'h0000, 0, 0, 8'h00, "rt_rd");
    access(0, 1, 16'h0010, 16'hBEEF, 5, 0, 8'h00, "hold_wr");
    access(0, 0, 16'h0010, 16'h0000, 5, 0, 8'h00, "hold_rd");

    // keyboard: overrun, then a character arriving on the KBDR read edge
    kb_strobe(1, 8'h41);
    access(1, 0, 16'hFE00, 16'h0000, 0, 0, 8'h00, "kb_sr1");
    kb_strobe(1, 8'h42);
    access(1, 0, 16'hFE02, 16'h0000, 0, 0, 8'h00, "kb_dr1");
    access(1, 0, 16'hFE00, 16'h0000, 0, 0, 8'h00, "kb_sr2");
    kb_strobe(1, 8'h43);
    access(1, 0, 16'hFE02, 16'h0000, 0, 1, 8'h44, "kb_race");
    access(1, 0, 16'hFE00, 16'h0000, 0, 0, 8'h00, "kb_sr3");
    access(1, 0, 16'hFE02, 16'h0000, 0, 0, 8'h00, "kb_dr2");

    // display
    access(1, 1, 16'hFE06, 16'h0058, 0, 0, 8'h00, "dsp_wr1");
    chk_dsp(1, "dsp_after_wr");
    access(1, 0, 16'hFE04, 16'h0000, 0, 0, 8'h00, "dsp_sr_busy");
    access(1, 1, 16'hFE06, 16'h0059, 0, 0, 8'h00, "dsp_wr2");
    chk_dsp(1, "dsp_dropped");
    dsp_pulse(1);
    chk_dsp(1, "dsp_consumed");
    access(1, 0, 16'hFE04, 16'h0000, 0, 0, 8'h00, "dsp_sr_free");

    // unmapped addresses
    access(1, 1, 16'h0000, 16'h1111, 0, 0, 8'h00, "um_pre");
    access(1, 0, 16'hC000, 16'h0000, 0, 0, 8'h00, "um_rd");
    access(1, 1, 16'hC000, 16'h5A5A, 0, 0, 8'h00, "um_wr");
    access(1, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, "um_alias");

    // reset one cycle into BUSY on a write
    access(2, 1, 16'h0007, 16'hAAAA, 0, 0, 8'h00, "rst_pre");
    access(2, 0, 16'h0007, 16'h0000, 0, 0, 8'h00, "rst_rd");
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0007; wdata[2] = 16'h5555;
    tick(); tick();
    rst_n[2] = 1'b0;
    #1;
    chk("rst_busy_ready", ready[2], 0);
    chk("rst_busy_rdata", rdata[2], 0);
    req[2] = 1'b0;
    tick(); tick();
    rst_n[2] = 1'b1;
    model_reset(2);
    tick();
    access(2, 0, 16'h0007, 16'h0000, 0, 0, 8'h00, "rst_post");
    // reset while ready is high
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 16'h0007;
    n = 0;
    while (!ready[2] && n < 20) begin tick(); n++; end
    chk("rst_ack_ready_hi", ready[2], 1);
    rst_n[2] = 1'b0;
    #1;
    chk("rst_ack_ready", ready[2], 0);
    chk("rst_ack_rdata", rdata[2], 0);
    req[2] = 1'b0;
    tick();
    rst_n[2] = 1'b1;
    model_reset(2);
    tick();

    // randomized traffic on every instance
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 60; i++) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: access(k, 1, 16'($urandom_range(0, 1023)), 16'($urandom), $urandom_range(0, 3),
                          1'($urandom), 8'($urandom), "rnd_wr");
          3, 4: begin
            a = 16'($urandom_range(0, 1023));
            access(k, !m_ok[k][a[9:0]], a, 16'($urandom), $urandom_range(0, 3), 0, 8'h00, "rnd_rd");
          end
          5: access(k, 1'($urandom), 16'($urandom_range(16'h0400, 16'hFFFF)), 16'($urandom),
                    $urandom_range(0, 2), 0, 8'h00, "rnd_um");
          6: access(k, 1'($urandom), 16'hFE00 + 16'(2 * $urandom_range(0, 3)), 16'($urandom),
                    $urandom_range(0, 2), 1'($urandom), 8'($urandom), "rnd_dev");
          7: kb_strobe(k, 8'($urandom));
          8: dsp_pulse(k);
          default: access(k, 0, 16'hFE00, 16'h0000, 0, 0, 8'h00, "rnd_kbsr");
        endcase
        chk_dsp(k, "rnd_dsp");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
